// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   RR_N        number of requesters (power of two)
//   RR_IDX_W    log2(RR_N), width of the round-robin pointer and winner index
//   state_t     arbiter FSM encoding (ST_IDLE / ST_GRANT)
//   RR_PTR_RST  pointer value after reset (requester 0 has top priority)
//   onehot_to_idx  binary index of a one-hot vector (0 for all-zero)
package rr_arbiter_8_pkg;

  localparam int RR_N     = 8;
  localparam int RR_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [RR_IDX_W-1:0] RR_PTR_RST = 3'd0;

  function automatic logic [RR_IDX_W-1:0] onehot_to_idx(input logic [RR_N-1:0] oh);
    logic [RR_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < RR_N; i++) begin
      if (oh[i]) idx = idx | RR_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// rr_pick: combinational round-robin pick.
// Finds the first set bit of req_masked, searching ptr, ptr+1 .. ptr+N-1 (mod N).
//   req_masked  in   N       candidate requests
//   ptr         in   IDX_W   highest-priority position
//   onehot      out  N       one-hot winner (zero if none)
//   idx         out  IDX_W   binary winner index (zero if none)
//   any         out  1       at least one candidate present
module rr_pick
  import rr_arbiter_8_pkg::*;
(
  input  logic [RR_N-1:0]     req_masked,
  input  logic [RR_IDX_W-1:0] ptr,
  output logic [RR_N-1:0]     onehot,
  output logic [RR_IDX_W-1:0] idx,
  output logic                any
);

  // Doubling the vector turns the wrap-around search into a plain shift:
  // bit k of rotated is requester (ptr + k) mod N.
  logic [2*RR_N-1:0] doubled;
  logic [RR_N-1:0]   rotated;

  always_comb begin
    doubled = {req_masked, req_masked} >> ptr;
    rotated = doubled[RR_N-1:0];
    idx     = '0;
    any     = 1'b0;
    onehot  = '0;
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int i = RR_N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        idx = ptr + RR_IDX_W'(i);
        any = 1'b1;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: registered round-robin arbiter for 8 level-sensitive requests.
// Optional feature macro: RR_ARB_LOCK_EN (adds the lock input).
//   clk          in   1  clock, all state on posedge
//   rst          in   1  asynchronous active-high reset
//   req          in   8  request lines, bit i = requester i
//   grant        out  8  registered one-hot grant, zero when grant_valid=0
//   grant_valid  out  1  grant holds a live winner
//   grant_ready  in   1  consumer accepts the grant
//   lock         in   1  (RR_ARB_LOCK_EN only) keep current owner on handshake
//   dbg_state    out  1  current FSM state
// Handshake: a transfer happens on a posedge where grant_valid & grant_ready.
// grant is held stable while grant_valid=1 and no transfer occurs; grant_ready
// is ignored while grant_valid=0.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RR_N-1:0] req,
  output logic [RR_N-1:0] grant,
  output logic            grant_valid,
  input  logic            grant_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic            lock,
`endif
  output state_t          dbg_state
);

  state_t              state;
  logic [RR_IDX_W-1:0] ptr;

  logic                handshake;
  logic                hold_owner;
  logic                rotate;
  logic [RR_IDX_W-1:0] win_idx;
  logic [RR_IDX_W-1:0] pick_ptr;
  logic [RR_N-1:0]     pick_req;
  logic [RR_N-1:0]     pick_onehot;
  logic [RR_IDX_W-1:0] pick_idx;
  logic                pick_any;

  assign handshake = grant_valid & grant_ready;

`ifdef RR_ARB_LOCK_EN
  assign hold_owner = lock;
`else
  assign hold_owner = 1'b0;
`endif

  assign rotate  = handshake & ~hold_owner;
  assign win_idx = onehot_to_idx(grant);

  // On a rotating handshake the next winner is chosen in the same cycle from the
  // advanced pointer, with the departing winner masked so it cannot re-win
  // immediately. Otherwise the plain request vector and current pointer are used.
  // The 3-bit add wraps 7 -> 0 naturally.
  assign pick_ptr = rotate ? (win_idx + RR_IDX_W'(1)) : ptr;
  assign pick_req = rotate ? (req & ~grant) : req;

  rr_pick u_pick (
    .req_masked (pick_req),
    .ptr        (pick_ptr),
    .onehot     (pick_onehot),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= RR_PTR_RST;
      grant       <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Without a rotating handshake everything is held, including while
          // the winner drops its request.
          if (rotate) begin
            ptr <= pick_ptr;
            if (pick_any) begin
              grant <= pick_onehot;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // pick_idx is the binary form of pick_onehot; the grant register keeps only
  // the one-hot form and the index is recovered from it when needed.
  logic unused_pick_idx;
  assign unused_pick_idx = ^pick_idx;

endmodule
